// File: rtl/ddr_access_arbiter.sv
// ddr_access_arbiter
// Shares one DDR burst controller among four requesters (JMP, DWR, DRD, IRD).
// Each grant runs exactly one read or write burst and then passes through a
// one-cycle DONE state. Read beats are returned only to the granted requester.
// Store words are buffered in a first-word-fall-through FIFO and may arrive
// before the store request is granted.
module ddr_access_arbiter #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH     = 16,
  parameter int CNT_WIDTH      = 10,
  parameter int DATA_BURST_LEN = 16,
  parameter int INST_BURST_LEN = 16,
  parameter int JMP_BURST_LEN  = 1,
  parameter int WFIFO_DEPTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      JMP_ADDR_read_req,
  input  logic                      DATA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr,
  input  logic                      DATA_store_req,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr,
  input  logic                      data_to_ddr_rdy,
  input  logic                      INST_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] INST_read_addr,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [CNT_WIDTH-1:0]      rd_burst_len,
  input  logic [DATA_WIDTH-1:0]     rd_burst_data,
  input  logic                      rd_burst_data_valid,
  input  logic                      rd_burst_finish,
  output logic                      wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [CNT_WIDTH-1:0]      wr_burst_len,
  input  logic                      wr_burst_data_req,
  output logic [DATA_WIDTH-1:0]     wr_burst_data,
  input  logic                      wr_burst_finish,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache,
  output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache,
  output logic [DATA_WIDTH-1:0]     INST_to_cache,
  output logic                      rd_burst_data_valid_data,
  output logic                      rd_burst_data_valid_jmp,
  output logic                      rd_burst_data_valid_inst,
  output logic [CNT_WIDTH-1:0]      rd_cnt_data,
  output logic [CNT_WIDTH-1:0]      rd_cnt_inst,
  output logic [3:0]                grant,
  output logic                      wr_fifo_ovf,
  output logic                      wr_underflow
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam logic [PTR_W:0]       FIFO_FULL_CNT  = (PTR_W+1)'(WFIFO_DEPTH);
  localparam logic [PTR_W:0]       FIFO_FILL_CNT  = (PTR_W+1)'(DATA_BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] DATA_LEN       = CNT_WIDTH'(DATA_BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] INST_LEN       = CNT_WIDTH'(INST_BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] JMP_LEN        = CNT_WIDTH'(JMP_BURST_LEN);

  typedef enum logic [2:0] {IDLE, RD_BURST, WR_FILL, WR_BURST, DONE} state_t;

  state_t state, state_next;

  logic [3:0]            pick;
  logic                  grant_edge;
  logic                  beat_data, beat_jmp, beat_inst;
  logic                  fin_data, fin_inst;

  logic [DATA_WIDTH-1:0] mem [WFIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  pop_req, pop_ok, push_ok, flush;

  // Fixed-priority pick among live requests: DWR > JMP > DRD > IRD
  always_comb begin
    pick = 4'b0000;
    if (DATA_store_req)         pick = 4'b0010;
    else if (JMP_ADDR_read_req) pick = 4'b0001;
    else if (DATA_read_req)     pick = 4'b0100;
    else if (INST_read_req)     pick = 4'b1000;
  end

  assign grant_edge = (state == IDLE) && (pick != 4'b0000);

  assign beat_data = rd_burst_data_valid && grant[2];
  assign beat_jmp  = rd_burst_data_valid && grant[0];
  assign beat_inst = rd_burst_data_valid && grant[3];
  assign fin_data  = rd_burst_finish && grant[2] && (state == RD_BURST);
  assign fin_inst  = rd_burst_finish && grant[3] && (state == RD_BURST);

  // State register; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state sequencing of one burst per grant
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (pick[1])                     state_next = WR_FILL;
                else if (pick != 4'b0000)        state_next = RD_BURST;
      RD_BURST: if (rd_burst_finish)             state_next = DONE;
      WR_FILL:  if (fifo_count >= FIFO_FILL_CNT) state_next = WR_BURST;
      WR_BURST: if (wr_burst_finish)             state_next = DONE;
      DONE:                                      state_next = IDLE;
      default:                                   state_next = IDLE;
    endcase
  end

  // Burst request strobes decoded from the current state
  always_comb begin
    rd_burst_req = (state == RD_BURST);
    wr_burst_req = (state == WR_BURST);
  end

  // Grant and latched burst attributes; grant is held through DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant         <= 4'b0000;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
      wr_burst_addr <= '0;
      wr_burst_len  <= '0;
    end else if (grant_edge) begin
      grant <= pick;
      if (pick[1]) begin
        wr_burst_addr <= DATA_write_addr;
        wr_burst_len  <= DATA_LEN;
      end else if (pick[0]) begin
        rd_burst_addr <= DATA_read_addr;
        rd_burst_len  <= JMP_LEN;
      end else if (pick[2]) begin
        rd_burst_addr <= DATA_read_addr;
        rd_burst_len  <= DATA_LEN;
      end else begin
        rd_burst_addr <= INST_read_addr;
        rd_burst_len  <= INST_LEN;
      end
    end else if (state == DONE) begin
      grant <= 4'b0000;
    end
  end

  // Registered read return, steered to the granted requester only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DATA_to_cache            <= '0;
      JMP_ADDR_to_cache        <= '0;
      INST_to_cache            <= '0;
      rd_burst_data_valid_data <= 1'b0;
      rd_burst_data_valid_jmp  <= 1'b0;
      rd_burst_data_valid_inst <= 1'b0;
      rd_cnt_data              <= '0;
      rd_cnt_inst              <= '0;
    end else begin
      rd_burst_data_valid_data <= beat_data;
      rd_burst_data_valid_jmp  <= beat_jmp;
      rd_burst_data_valid_inst <= beat_inst;
      if (beat_data) DATA_to_cache <= rd_burst_data;
      if (beat_inst) INST_to_cache <= rd_burst_data;
      if (beat_jmp)
        JMP_ADDR_to_cache <= {{(DDR_ADDR_WIDTH-DATA_WIDTH){1'b0}}, rd_burst_data};
      if (grant_edge && pick[2]) rd_cnt_data <= '0;
      else rd_cnt_data <= rd_cnt_data + CNT_WIDTH'(beat_data) + CNT_WIDTH'(fin_data);
      if (grant_edge && pick[3]) rd_cnt_inst <= '0;
      else rd_cnt_inst <= rd_cnt_inst + CNT_WIDTH'(beat_inst) + CNT_WIDTH'(fin_inst);
    end
  end

  assign fifo_full     = (fifo_count == FIFO_FULL_CNT);
  assign fifo_empty    = (fifo_count == '0);
  assign pop_req       = wr_burst_data_req && (state == WR_BURST);
  assign pop_ok        = pop_req && !fifo_empty;
  assign push_ok       = data_to_ddr_rdy && (!fifo_full || pop_ok);
  assign flush         = (state == WR_BURST) && wr_burst_finish;
  assign wr_burst_data = fifo_empty ? '0 : mem[rd_ptr];

  // Store FIFO pointers, occupancy and sticky error flags; finish flushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      wr_fifo_ovf  <= 1'b0;
      wr_underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop_ok})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
        if (data_to_ddr_rdy && !push_ok) wr_fifo_ovf <= 1'b1;
      end
      if (pop_req && fifo_empty) wr_underflow <= 1'b1;
    end
  end

  // Store FIFO word storage
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= DATA_to_ddr;
  end

endmodule
